phase_ctrl: RTL and testbench
=============================

Name: phase_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit processor core.
- Steps each instruction through five fixed phases: P1 fetch, P2 decode/register read, P3 execute, P4 memory, P5 writeback/branch.
- Drives datapath strobes around the ALU/shifter, register file, memory and PC.
- Owns the SZCV flag register and resolves conditional branches from it.

Parameters:
- AUTO_RUN, 0: 1 = leave IDLE and start P1 on the first clock after reset release; 0 = wait for a run pulse.
- FLAG_RST, 4'b0000: reset value of the flag register {S,Z,C,V}.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start pulse; sampled only in IDLE.
- instr  in  16  instruction word from memory; valid during P1.
- code  in  4  {S,Z,C,V} from the ALU/shifter; valid during P3.
- phase  out  3  0 = IDLE, 1–5 = P1–P5, 7 = HALT.
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC load strobe.
- pc_sel  out  1  0 = PC+1, 1 = branch target.
- reg_we  out  1  register file write strobe.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = immediate.
- mem_re  out  1  data memory read strobe.
- mem_we  out  1  data memory write strobe.
- out_we  out  1  output port write strobe.
- flags  out  4  current flag register.
- halted  out  1  high in HALT.

Behaviour:
- Reset (asynchronous): state IDLE, IR 0, flags FLAG_RST, every strobe 0, halted 0. A reset mid-instruction aborts it with no writes.
- Decode from the latched IR:
  - op1 = [15:14], op2 = [13:11], op3 = [7:4], cond = [10:8].
- op1 = 11 (ALU/shift group), by op3:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 CMP, 0110 MOV.
  - 1000–1011 shifts (SLL, SLR, SRL, SRA).
  - 1100 IN, 1101 OUT, 1111 HLT.
  - Any other op3 is a NOP.
- op1 = 00 is LD; op1 = 01 is ST.
- op1 = 10, by op2:
  - 000 LI.
  - 100 B (unconditional).
  - 111 conditional branch, by cond: 000 BE (Z), 001 BLT (S^V), 010 BLE (Z|(S^V)), 011 BNE (!Z). Other cond values are never taken.
  - Other op2 values are a NOP.
- State transitions:
  - IDLE→P1 when run=1.
  - P1→P2→P3→P4→P5.
  - P5→P1, except HLT: P5→HALT.
  - HALT holds until reset; run is ignored.
- Every instruction takes exactly 5 cycles; no early exit.
- Strobes are single-cycle, combinational from state + IR, and 0 outside their phase:
  - P1: ir_we=1, pc_we=1, pc_sel=0.
  - P3: flag register loads code at the end of P3 for ADD, SUB, AND, OR, XOR, CMP, MOV and the shifts only.
  - P4: mem_re=1 for LD; mem_we=1 for ST.
  - P5, register write: reg_we=1 for ALU ops except CMP/OUT/HLT/NOP, wb_sel=0. Also for IN, wb_sel=0. For LD, wb_sel=1. For LI, wb_sel=2.
  - P5, output: out_we=1 for OUT.
  - P5, branch: pc_we=1, pc_sel=1 when the branch is taken, evaluated on the flag register (already updated by a preceding instruction).
- Flags are not changed by LD, ST, LI, branches, IN, OUT, HLT or NOP.
- wb_sel is 0 whenever reg_we=0.

Optional Feature:
- PHASE_CTRL_STEP_EN defined: adds input step_mode (1 bit). When step_mode=1 at P5, go to IDLE instead of P1; the next run pulse executes exactly one more instruction. HLT still goes to HALT.
- Undefined: no step_mode port; behaviour exactly as above.

Decomposition:
- Package phase_ctrl_pkg holds:
  - state encoding constants (IDLE, P1–P5, HALT);
  - op1/op2/op3/cond field constants;
  - wb_sel codes.
- One combinational sub-module, branch_eval: inputs flags and cond, output taken. Shared with a future pipelined core.

Test Plan:
- Reset then run pulse; instr=16'hD100 (ADD rd=1, rs=2), code=4'b0100 in P3 → ir_we and pc_we in P1; flags=4'b0100 after P3; reg_we=1 with wb_sel=0 only in P5; back to P1 at cycle 6.
- CMP 16'hD150 with code=4'b0100, then BE 16'hB805 → CMP gives reg_we=0 throughout; at BE P5, pc_we=1 and pc_sel=1. Repeat with code=4'b0000 → pc_we=0 in the BE P5.
- LD 16'h0A00 then ST 16'h4A00 → LD: mem_re in P4, reg_we with wb_sel=1 in P5. ST: mem_we in P4, no reg_we. flags unchanged throughout.
- HLT 16'hC0F0 → after P5, phase=7 and halted=1; a later run pulse causes no strobes.
- Assert reset during P3 of an ADD → all outputs 0 within the same cycle; phase=0; flags=FLAG_RST; no reg_we ever seen for that ADD.
- With PHASE_CTRL_STEP_EN, step_mode=1 and two ADDs queued → one instruction per run pulse; phase=0 between pulses.

Source files
------------

// File: rtl/phase_ctrl_pkg.sv
// Shared encodings for the phase sequencer: state/phase codes, instruction
// field values and writeback source selects.
package phase_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StP1   = 3'd1,
    StP2   = 3'd2,
    StP3   = 3'd3,
    StP4   = 3'd4,
    StP5   = 3'd5,
    StHalt = 3'd7
  } state_e;

  localparam logic [1:0] Op1Ld  = 2'b00;
  localparam logic [1:0] Op1St  = 2'b01;
  localparam logic [1:0] Op1Imm = 2'b10;
  localparam logic [1:0] Op1Alu = 2'b11;

  localparam logic [2:0] Op2Li = 3'b000;
  localparam logic [2:0] Op2B  = 3'b100;
  localparam logic [2:0] Op2Bc = 3'b111;

  localparam logic [3:0] Op3Add = 4'b0000;
  localparam logic [3:0] Op3Sub = 4'b0001;
  localparam logic [3:0] Op3And = 4'b0010;
  localparam logic [3:0] Op3Or  = 4'b0011;
  localparam logic [3:0] Op3Xor = 4'b0100;
  localparam logic [3:0] Op3Cmp = 4'b0101;
  localparam logic [3:0] Op3Mov = 4'b0110;
  localparam logic [3:0] Op3Sll = 4'b1000;
  localparam logic [3:0] Op3Slr = 4'b1001;
  localparam logic [3:0] Op3Srl = 4'b1010;
  localparam logic [3:0] Op3Sra = 4'b1011;
  localparam logic [3:0] Op3In  = 4'b1100;
  localparam logic [3:0] Op3Out = 4'b1101;
  localparam logic [3:0] Op3Hlt = 4'b1111;

  localparam logic [2:0] CondBe  = 3'b000;
  localparam logic [2:0] CondBlt = 3'b001;
  localparam logic [2:0] CondBle = 3'b010;
  localparam logic [2:0] CondBne = 3'b011;

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbImm = 2'd2;

  // ALU/shift-group ops whose result code is captured into the flag register.
  function automatic logic is_flag_op(input logic [3:0] op3);
    case (op3)
      Op3Add, Op3Sub, Op3And, Op3Or, Op3Xor, Op3Cmp, Op3Mov,
      Op3Sll, Op3Slr, Op3Srl, Op3Sra: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phase_ctrl_branch_eval.sv
// Conditional branch resolution from the {S,Z,C,V} flags; kept standalone so
// a pipelined core can reuse it.
module branch_eval
  import phase_ctrl_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic s, z, v;
  logic unused_carry;

  assign s            = flags[3];
  assign z            = flags[2];
  assign unused_carry = flags[1];
  assign v            = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CondBe:  taken = z;
      CondBlt: taken = s ^ v;
      CondBle: taken = z | (s ^ v);
      CondBne: taken = ~z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/phase_ctrl.sv
// Five-phase multi-cycle sequencer with flag register and branch resolution.
// Optional single-step support is enabled by defining PHASE_CTRL_STEP_EN.
module phase_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter bit         AUTO_RUN = 1'b0,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
`ifdef PHASE_CTRL_STEP_EN
  input  logic        step_mode,
`endif
  input  logic [15:0] instr,
  input  logic [3:0]  code,
  output logic [2:0]  phase,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic        out_we,
  output logic [3:0]  flags,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;
  logic        auto_q, auto_d;
  logic        step;

`ifdef PHASE_CTRL_STEP_EN
  assign step = step_mode;
`else
  assign step = 1'b0;
`endif

  logic [1:0] op1;
  logic [2:0] op2, cond;
  logic [3:0] op3;
  logic       unused_ir_lo;

  assign op1          = ir_q[15:14];
  assign op2          = ir_q[13:11];
  assign cond         = ir_q[10:8];
  assign op3          = ir_q[7:4];
  assign unused_ir_lo = ^ir_q[3:0];

  logic is_alu, alu_flag, alu_wr, is_ld, is_st, is_li, is_b, is_bc, is_out, is_hlt;
  logic cond_taken, br_taken;

  always_comb begin
    is_alu   = (op1 == Op1Alu);
    alu_flag = is_alu && is_flag_op(op3);
    alu_wr   = (alu_flag && (op3 != Op3Cmp)) || (is_alu && (op3 == Op3In));
    is_out   = is_alu && (op3 == Op3Out);
    is_hlt   = is_alu && (op3 == Op3Hlt);
    is_ld    = (op1 == Op1Ld);
    is_st    = (op1 == Op1St);
    is_li    = (op1 == Op1Imm) && (op2 == Op2Li);
    is_b     = (op1 == Op1Imm) && (op2 == Op2B);
    is_bc    = (op1 == Op1Imm) && (op2 == Op2Bc);
    br_taken = is_b || (is_bc && cond_taken);
  end

  branch_eval u_branch_eval (
    .flags (flags_q),
    .cond  (cond),
    .taken (cond_taken)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    auto_d  = auto_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    reg_we  = 1'b0;
    wb_sel  = WbAlu;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    out_we  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run || auto_q) begin
          state_d = StP1;
          auto_d  = 1'b0;
        end
      end
      StP1: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        ir_d    = instr;
        state_d = StP2;
      end
      StP2: state_d = StP3;
      StP3: begin
        if (alu_flag) flags_d = code;
        state_d = StP4;
      end
      StP4: begin
        mem_re  = is_ld;
        mem_we  = is_st;
        state_d = StP5;
      end
      StP5: begin
        reg_we = alu_wr || is_ld || is_li;
        if (is_ld)      wb_sel = WbMem;
        else if (is_li) wb_sel = WbImm;
        out_we = is_out;
        pc_we  = br_taken;
        pc_sel = br_taken;
        if (is_hlt)    state_d = StHalt;
        else if (step) state_d = StIdle;
        else           state_d = StP1;
      end
      StHalt:  halted = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      flags_q <= FLAG_RST;
      auto_q  <= AUTO_RUN;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      auto_q  <= auto_d;
    end
  end

  assign phase = state_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// Bench for phase_ctrl: directed sequences plus random instructions checked
// against a mnemonic-level model of per-phase strobes and flag updates.
module tb_phase_ctrl;

  localparam logic [3:0] FLAG_RST_TB = 4'b0101;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic [15:0] instr = '0;
  logic [3:0]  code  = '0;
`ifdef PHASE_CTRL_STEP_EN
  logic        step_mode = 1'b0;
`endif
  logic [2:0]  phase;
  logic        ir_we, pc_we, pc_sel, reg_we, mem_re, mem_we, out_we, halted;
  logic [1:0]  wb_sel;
  logic [3:0]  flags;

  phase_ctrl #(
    .AUTO_RUN (1'b0),
    .FLAG_RST (FLAG_RST_TB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
`ifdef PHASE_CTRL_STEP_EN
    .step_mode (step_mode),
`endif
    .instr     (instr),
    .code      (code),
    .phase     (phase),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .out_we    (out_we),
    .flags     (flags),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] phase;
    logic       ir_we, pc_we, pc_sel, reg_we;
    logic [1:0] wb_sel;
    logic       mem_re, mem_we, out_we;
    logic [3:0] flags;
    logic       halted;
  } view_t;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] model_flags;
  string      alu_names [16] = '{"ADD", "SUB", "AND", "OR", "XOR", "CMP", "MOV", "NOP",
                                 "SLL", "SLR", "SRL", "SRA", "IN", "OUT", "NOP", "HLT"};

  function automatic string mnem(input logic [15:0] i);
    case (i[15:14])
      2'b00: return "LD";
      2'b01: return "ST";
      2'b10: begin
        if (i[13:11] == 3'b000) return "LI";
        if (i[13:11] == 3'b100) return "B";
        if (i[13:11] == 3'b111) return "BC";
        return "NOP";
      end
      default: return alu_names[i[7:4]];
    endcase
  endfunction

  function automatic bit writes_flags(input string m);
    case (m)
      "ADD", "SUB", "AND", "OR", "XOR", "CMP", "MOV", "SLL", "SLR", "SRL", "SRA": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writes_reg(input string m);
    case (m)
      "ADD", "SUB", "AND", "OR", "XOR", "MOV", "SLL", "SLR", "SRL", "SRA",
      "IN", "LD", "LI": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit taken(input string m, input logic [15:0] i, input logic [3:0] f);
    bit s, z, v;
    s = f[3];
    z = f[2];
    v = f[0];
    if (m == "B") return 1'b1;
    if (m != "BC") return 1'b0;
    case (i[10:8])
      3'd0:    return z;
      3'd1:    return s != v;
      3'd2:    return z || (s != v);
      3'd3:    return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic view_t observe();
    view_t o;
    o.phase  = phase;
    o.ir_we  = ir_we;
    o.pc_we  = pc_we;
    o.pc_sel = pc_sel;
    o.reg_we = reg_we;
    o.wb_sel = wb_sel;
    o.mem_re = mem_re;
    o.mem_we = mem_we;
    o.out_we = out_we;
    o.flags  = flags;
    o.halted = halted;
    return o;
  endfunction

  function automatic view_t idle_view();
    view_t e;
    e       = '0;
    e.flags = model_flags;
    return e;
  endfunction

  task automatic check(input string tag, input view_t exp);
    view_t got;
    got = observe();
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in P1; leaves at the falling edge after P5.
  task automatic exec(input logic [15:0] ins, input logic [3:0] cd);
    string m;
    view_t e;
    m = mnem(ins);
    for (int k = 1; k <= 5; k++) begin
      instr   = ins;
      code    = cd;
      e       = idle_view();
      e.phase = k[2:0];
      case (k)
        1: begin
          e.ir_we = 1'b1;
          e.pc_we = 1'b1;
        end
        4: begin
          e.mem_re = (m == "LD");
          e.mem_we = (m == "ST");
        end
        5: begin
          if (writes_reg(m)) begin
            e.reg_we = 1'b1;
            e.wb_sel = (m == "LD") ? 2'd1 : (m == "LI") ? 2'd2 : 2'd0;
          end
          e.out_we = (m == "OUT");
          if (taken(m, ins, model_flags)) begin
            e.pc_we  = 1'b1;
            e.pc_sel = 1'b1;
          end
        end
        default: ;
      endcase
      check($sformatf("%s_%h_P%0d", m, ins, k), e);
      @(posedge clk);
      if (k == 3 && writes_flags(m)) model_flags = cd;
      @(negedge clk);
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog phase=%0d expected=finished", phase);
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] ins;
    view_t       e;
    model_flags = FLAG_RST_TB;
    repeat (2) @(negedge clk);
    check("reset_hold", idle_view());
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_run", idle_view());

    pulse_run();
    exec(16'hD100, 4'b0100);
    exec(16'hD150, 4'b0100);
    exec(16'hB805, 4'($urandom));
    exec(16'hD150, 4'b0000);
    exec(16'hB805, 4'($urandom));
    exec(16'h0A00, 4'($urandom));
    exec(16'h4A00, 4'($urandom));

    for (int n = 0; n < 150; n++) begin
      ins = 16'($urandom);
      if (ins[15:14] == 2'b10 && $urandom_range(0, 1) == 1) ins[13:11] = 3'b111;
      if (mnem(ins) == "HLT") ins[7:4] = 4'b0000;
      exec(ins, 4'($urandom));
    end

    // Abort an ADD in P3: nothing it would have written may appear.
    instr = 16'hD100;
    code  = 4'b1111;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    e       = idle_view();
    e.phase = 3'd3;
    check("abort_at_p3", e);
    reset = 1'b1;
    #1;
    model_flags = FLAG_RST_TB;
    check("abort_reset", idle_view());
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle", idle_view());
    end

`ifdef PHASE_CTRL_STEP_EN
    step_mode = 1'b1;
    for (int n = 0; n < 2; n++) begin
      pulse_run();
      exec(16'hD100, 4'($urandom));
      check("step_idle", idle_view());
      @(negedge clk);
      check("step_idle_hold", idle_view());
    end
    step_mode = 1'b0;
`endif

    pulse_run();
    exec(16'hC0F0, 4'b1111);
    e        = idle_view();
    e.phase  = 3'd7;
    e.halted = 1'b1;
    check("halt", e);
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    repeat (4) begin
      check("halt_hold", e);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
